// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive products from the serial multiplier and hands the
// finished sum downstream over a valid/ready port (dot-product accumulator).
module product_accumulator #(
  parameter int PW      = 8,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [PW-1:0]    prod_data,
  output logic             prod_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_data,
  input  logic             sum_ready,
  output logic             overflow,
  output logic [7:0]       term_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] sum_reg;
  logic             overflow_reg;
  logic             prod_ready_reg;
  logic             sum_valid_reg;
  logic [7:0]       term_cnt_reg;

  logic [ACC_W:0]   add_next;
  logic             last_term;

  // One extra bit captures the carry out of the accumulator width.
  assign add_next  = {1'b0, acc_reg} + (ACC_W+1)'(prod_data);
  assign last_term = (term_cnt_reg == 8'(N_TERMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      acc_reg        <= '0;
      sum_reg        <= '0;
      overflow_reg   <= 1'b0;
      term_cnt_reg   <= 8'd0;
      prod_ready_reg <= 1'b1;
      sum_valid_reg  <= 1'b0;
    end else if (clear) begin
      // A product offered alongside clear is consumed but deliberately dropped.
      state_reg      <= ACCUM;
      acc_reg        <= '0;
      overflow_reg   <= 1'b0;
      term_cnt_reg   <= 8'd0;
      prod_ready_reg <= 1'b1;
      sum_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (prod_valid) begin
            acc_reg      <= add_next[ACC_W-1:0];
            overflow_reg <= overflow_reg | add_next[ACC_W];
            term_cnt_reg <= term_cnt_reg + 8'd1;
            if (last_term) begin
              sum_reg        <= add_next[ACC_W-1:0];
              state_reg      <= HOLD;
              prod_ready_reg <= 1'b0;
              sum_valid_reg  <= 1'b1;
            end
          end
        end
        HOLD: begin
          // No product is taken on the handoff edge; prod_ready rises after it.
          if (sum_ready) begin
            state_reg      <= ACCUM;
            acc_reg        <= '0;
            overflow_reg   <= 1'b0;
            term_cnt_reg   <= 8'd0;
            prod_ready_reg <= 1'b1;
            sum_valid_reg  <= 1'b0;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign prod_ready = prod_ready_reg;
  assign sum_valid  = sum_valid_reg;
  assign sum_data   = sum_reg;
  assign overflow   = overflow_reg;
  assign term_cnt   = term_cnt_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: three accumulator instances (default, 8-bit/2-term, 1-term)
// checked against hand-computed sums.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: PW=8, ACC_W=16, N_TERMS=4
  logic        rst0, clear0, pv0, sr0;
  logic [7:0]  pd0;
  logic        pr0, sv0, ov0;
  logic [15:0] sd0;
  logic [7:0]  tc0;

  // Instance 1: ACC_W=8, N_TERMS=2
  logic        rst1, clear1, pv1, sr1;
  logic [7:0]  pd1;
  logic        pr1, sv1, ov1;
  logic [7:0]  sd1;
  logic [7:0]  tc1;

  // Instance 2: N_TERMS=1
  logic        rst2, clear2, pv2, sr2;
  logic [7:0]  pd2;
  logic        pr2, sv2, ov2;
  logic [15:0] sd2;
  logic [7:0]  tc2;

  product_accumulator #(.PW(8), .ACC_W(16), .N_TERMS(4)) dut0 (
    .clk(clk), .rst(rst0), .clear(clear0), .prod_valid(pv0), .prod_data(pd0),
    .prod_ready(pr0), .sum_valid(sv0), .sum_data(sd0), .sum_ready(sr0),
    .overflow(ov0), .term_cnt(tc0));

  product_accumulator #(.PW(8), .ACC_W(8), .N_TERMS(2)) dut1 (
    .clk(clk), .rst(rst1), .clear(clear1), .prod_valid(pv1), .prod_data(pd1),
    .prod_ready(pr1), .sum_valid(sv1), .sum_data(sd1), .sum_ready(sr1),
    .overflow(ov1), .term_cnt(tc1));

  product_accumulator #(.PW(8), .ACC_W(16), .N_TERMS(1)) dut2 (
    .clk(clk), .rst(rst2), .clear(clear2), .prod_valid(pv2), .prod_data(pd2),
    .prod_ready(pr2), .sum_valid(sv2), .sum_data(sd2), .sum_ready(sr2),
    .overflow(ov2), .term_cnt(tc2));

  typedef struct {
    logic [7:0]  p[4];
    int          gap;
    logic [15:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed0(input logic [7:0] d);
    pv0 = 1'b1; pd0 = d;
    tick();
    pv0 = 1'b0;
  endtask

  task automatic feed1(input logic [7:0] d);
    pv1 = 1'b1; pd1 = d;
    tick();
    pv1 = 1'b0;
  endtask

  task automatic feed2(input logic [7:0] d);
    pv2 = 1'b1; pd2 = d;
    tick();
    pv2 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{p: '{8'd6, 8'd15, 8'd225, 8'd0},     gap: 4, exp_sum: 16'd246,  exp_ovf: 1'b0};
    vecs[1] = '{p: '{8'd1, 8'd2, 8'd3, 8'd4},        gap: 0, exp_sum: 16'd10,   exp_ovf: 1'b0};
    vecs[2] = '{p: '{8'd255, 8'd255, 8'd255, 8'd255}, gap: 1, exp_sum: 16'd1020, exp_ovf: 1'b0};
    vecs[3] = '{p: '{8'd0, 8'd0, 8'd0, 8'd0},        gap: 2, exp_sum: 16'd0,    exp_ovf: 1'b0};

    rst0 = 1; clear0 = 0; pv0 = 0; pd0 = 0; sr0 = 0;
    rst1 = 1; clear1 = 0; pv1 = 0; pd1 = 0; sr1 = 0;
    rst2 = 1; clear2 = 0; pv2 = 0; pd2 = 0; sr2 = 0;
    tick(); tick();
    rst0 = 0; rst1 = 0; rst2 = 0;

    chk("reset prod_ready", 32'(pr0), 32'd1);
    chk("reset sum_valid", 32'(sv0), 32'd0);
    chk("reset sum_data", 32'(sd0), 32'd0);
    chk("reset overflow", 32'(ov0), 32'd0);
    chk("reset term_cnt", 32'(tc0), 32'd0);

    // Table-driven dot products with sum_ready held high.
    sr0 = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int t = 0; t < 4; t++) begin
        feed0(vecs[v].p[t]);
        if (t < 3) begin
          chk($sformatf("vec%0d term_cnt", v), 32'(tc0), 32'(t + 1));
          chk($sformatf("vec%0d no early sum", v), 32'(sv0), 32'd0);
          for (int g = 0; g < vecs[v].gap; g++) tick();
        end
      end
      chk($sformatf("vec%0d sum_valid", v), 32'(sv0), 32'd1);
      chk($sformatf("vec%0d sum_data", v), 32'(sd0), 32'(vecs[v].exp_sum));
      chk($sformatf("vec%0d overflow", v), 32'(ov0), 32'(vecs[v].exp_ovf));
      chk($sformatf("vec%0d term_cnt held", v), 32'(tc0), 32'd4);
      tick();
      chk($sformatf("vec%0d sum pulse ends", v), 32'(sv0), 32'd0);
      chk($sformatf("vec%0d term_cnt restart", v), 32'(tc0), 32'd0);
    end

    // Reset mid-sum after two products.
    feed0(8'd5); feed0(8'd7);
    rst0 = 1'b1; tick(); tick(); rst0 = 1'b0;
    chk("midrst prod_ready", 32'(pr0), 32'd1);
    chk("midrst sum_valid", 32'(sv0), 32'd0);
    chk("midrst term_cnt", 32'(tc0), 32'd0);
    chk("midrst overflow", 32'(ov0), 32'd0);
    feed0(8'd2); feed0(8'd3); feed0(8'd4); feed0(8'd5);
    chk("midrst fresh sum", 32'(sd0), 32'd14);
    chk("midrst fresh valid", 32'(sv0), 32'd1);
    tick();

    // Backpressure: hold the sum while sum_ready is low.
    sr0 = 1'b0;
    feed0(8'd1); feed0(8'd2); feed0(8'd3); feed0(8'd4);
    pv0 = 1'b1; pd0 = 8'd7;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold%0d sum_valid", c), 32'(sv0), 32'd1);
      chk($sformatf("bp hold%0d sum_data", c), 32'(sd0), 32'd10);
      chk($sformatf("bp hold%0d prod_ready", c), 32'(pr0), 32'd0);
      chk($sformatf("bp hold%0d term_cnt", c), 32'(tc0), 32'd4);
      tick();
    end
    sr0 = 1'b1;
    tick();
    sr0 = 1'b0;
    chk("bp handoff sum_valid", 32'(sv0), 32'd0);
    chk("bp handoff term_cnt", 32'(tc0), 32'd0);
    chk("bp handoff prod_ready", 32'(pr0), 32'd1);
    tick();
    pv0 = 1'b0;
    chk("bp 5th is term1", 32'(tc0), 32'd1);
    feed0(8'd2); feed0(8'd3); feed0(8'd4);
    chk("bp next sum", 32'(sd0), 32'd16);
    sr0 = 1'b1; tick(); sr0 = 1'b0;

    // clear with a product in the same cycle drops the product.
    feed0(8'd9); feed0(8'd9);
    clear0 = 1'b1; pv0 = 1'b1; pd0 = 8'd50;
    tick();
    clear0 = 1'b0; pv0 = 1'b0;
    chk("clear term_cnt", 32'(tc0), 32'd0);
    chk("clear sum_valid", 32'(sv0), 32'd0);
    feed0(8'd1); feed0(8'd1); feed0(8'd1); feed0(8'd1);
    chk("clear next sum", 32'(sd0), 32'd4);
    chk("clear next valid", 32'(sv0), 32'd1);

    // clear in HOLD discards the sum even with sum_ready high.
    clear0 = 1'b1; sr0 = 1'b1;
    tick();
    clear0 = 1'b0; sr0 = 1'b0;
    chk("clear hold sum_valid", 32'(sv0), 32'd0);
    chk("clear hold term_cnt", 32'(tc0), 32'd0);
    chk("clear hold prod_ready", 32'(pr0), 32'd1);

    // Overflow on the 8-bit, 2-term instance.
    sr1 = 1'b1;
    feed1(8'd200);
    chk("ovf first term no carry", 32'(ov1), 32'd0);
    feed1(8'd100);
    chk("ovf sum_data wrap", 32'(sd1), 32'd44);
    chk("ovf flag", 32'(ov1), 32'd1);
    tick();
    chk("ovf cleared on handoff", 32'(ov1), 32'd0);
    feed1(8'd3); feed1(8'd4);
    chk("ovf next sum", 32'(sd1), 32'd7);
    chk("ovf next flag", 32'(ov1), 32'd0);
    tick();

    // Single-term instance: each product is its own sum.
    sr2 = 1'b1;
    feed2(8'd49);
    chk("n1 sum0 valid", 32'(sv2), 32'd1);
    chk("n1 sum0 data", 32'(sd2), 32'd49);
    chk("n1 sum0 term_cnt", 32'(tc2), 32'd1);
    tick();
    chk("n1 sum0 one cycle", 32'(sv2), 32'd0);
    feed2(8'd81);
    chk("n1 sum1 valid", 32'(sv2), 32'd1);
    chk("n1 sum1 data", 32'(sd2), 32'd81);
    tick();
    chk("n1 sum1 one cycle", 32'(sv2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream stage of the 4x4 serial multiplier. It consumes one 8-bit product per valid/ready transfer and sums N_TERMS consecutive products into a wider accumulator. It then presents the finished sum on a valid/ready output port, so the datapath can form dot products (sum of a_i*b_i) from a single shared serial multiplier.

Parameters:
PW, 8, product input width; must equal the multiplier product width.
ACC_W, 16, accumulator and sum width; must be >= PW.
N_TERMS, 4, products per sum; legal range 1..255.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous abort: drop partial or held sum, restart at term 0
prod_valid  input  1  prod_data holds a product
prod_data  input  PW  unsigned product value
prod_ready  output  1  block can accept a product this cycle
sum_valid  output  1  sum_data holds a completed sum
sum_data  output  ACC_W  completed sum, modulo 2^ACC_W
sum_ready  input  1  consumer takes sum_data this cycle
overflow  output  1  a carry out of ACC_W occurred while forming the current/held sum
term_cnt  output  8  number of products accepted into the current sum

Behaviour:
- Reset is synchronous and active-high on rst. Single clock domain, clk.
- Reset values: state=ACCUM, acc=0, term_cnt=0, prod_ready=1, sum_valid=0, sum_data=0, overflow=0.
- Priority each cycle: rst > clear > normal operation.
- The FSM has two states, ACCUM and HOLD.
- ACCUM state:
  - prod_ready=1 and sum_valid=0.
  - A transfer happens when prod_valid && prod_ready. On a transfer: acc <= acc + zero-extended prod_data, truncated to ACC_W. The carry out is ORed into overflow. term_cnt increments.
  - If the transfer is the N_TERMS-th term: sum_data <= acc + prod_data, same rule; overflow includes this term's carry; state moves to HOLD.
  - sum_valid asserts the cycle after the final transfer. Latency from the last product to the sum is 1 cycle.
  - prod_valid=0 in ACCUM holds all state.
- HOLD state:
  - prod_ready=0. sum_valid=1. sum_data, overflow and term_cnt (=N_TERMS) are stable.
  - The block drives prod_ready low in HOLD, so prod_valid is ignored; the upstream holds its product per valid/ready rules.
  - sum_valid && sum_ready: next cycle state=ACCUM, acc=0, term_cnt=0, overflow=0, sum_valid=0.
  - sum_data keeps its last value after handoff; it is only meaningful while sum_valid=1.
  - There is no same-cycle product acceptance on handoff; the first product of the next sum is taken no earlier than the cycle after sum_ready.
- clear:
  - In any state, next cycle: state=ACCUM, acc=0, term_cnt=0, overflow=0, sum_valid=0.
  - A product presented in the same cycle as clear is NOT accumulated, even though prod_ready=1 in ACCUM. The upstream sees the transfer as completed and the product is dropped.
  - A held sum is discarded even if sum_ready is high in the same cycle; the consumer must not treat that cycle as a valid handoff.
- N_TERMS=1: each accepted product goes straight to HOLD with sum_data=prod_data.
- Wrap-around: arithmetic is modulo 2^ACC_W. overflow is sticky per sum and is never cleared mid-sum except by clear or rst.
- Reset mid-operation (ACCUM with partial sum, or HOLD) returns to reset values on the next edge. No output pulse results.
- The block never back-pressures inside ACCUM. Throughput is one product per cycle, so the 5-cycle multiplier cadence is never a bottleneck.

Test Plan:
- Reset: assert rst 2 cycles mid-sum (after 2 products) -> prod_ready=1, sum_valid=0, term_cnt=0, overflow=0. The next 4 products form a fresh sum.
- Dot product: N_TERMS=4; products 6, 15, 225, 0 with gaps of 4 idle cycles, sum_ready=1 -> sum_valid pulses 1 cycle after the 4th transfer with sum_data=246, overflow=0.
- Backpressure: products 1, 2, 3, 4 back-to-back, sum_ready=0 for 5 cycles -> sum_data=10 held stable, prod_ready=0 throughout HOLD. A 5th product with prod_valid=1 is not taken until the cycle after sum_ready=1, and it becomes term 1 of the next sum.
- Overflow: ACC_W=8, N_TERMS=2; products 200 and 100 -> sum_data=44, overflow=1. The next sum (3, 4) gives sum_data=7, overflow=0.
- clear: after products 9 and 9, assert clear with prod_valid=1 and prod_data=50 in the same cycle -> term_cnt=0, the 50 is dropped. The next 4 products 1, 1, 1, 1 yield sum_data=4.
- N_TERMS=1: products 49, 81 with sum_ready=1 -> two sums, 49 then 81, each with sum_valid high for exactly one cycle.
